// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences the board PLL through reset, waits for lock and qualifies it.
// Only after lock has been continuously stable does it release the
// design-wide system reset. If lock does not arrive in time, or if lock is
// lost while running, the PLL is reset again and the attempt is counted.
// Everything runs on the reference clock, because the PLL outputs cannot be
// trusted while the PLL is unlocked.
//
// Parameters:
//   PLL_RST_CYCLES  cycles pll_rst is held high per attempt (>=1)
//   LOCK_TIMEOUT    cycles to wait for lock after pll_rst is released (>=1)
//   STABLE_CYCLES   cycles locked_s must stay high before release (>=1)
//   CNT_W           shared counter width; holds max(parameters)-1
//
// Ports:
//   refclk        in   reference clock (50 MHz)
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL locked, asynchronous to refclk
//   sw_reset_req  in   level request to restart the PLL (highest priority)
//   pll_rst       out  PLL reset, active-high
//   sys_rst_n     out  downstream system reset, active-low
//   lock_ok       out  high while running with a qualified lock
//   lock_lost     out  one-cycle pulse when lock drops while running
//   retry_count   out  saturating count of PLL re-reset attempts
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       lock_ok,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    QUALIFY   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so a state that
  // must last N cycles leaves when the counter shows N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sync_meta;
  logic             locked_s;
  logic             retry_inc;
  logic             lost_nxt;

  // Two-flop synchronizer for the asynchronous lock indication. The first
  // flop may go metastable; only locked_s is used by the state machine.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of the others, exactly as hardware.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      locked_s  <= sync_meta;
    end
  end

  // Next-state decode. A software restart overrides everything and is never
  // counted as a retry.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    lost_nxt  = 1'b0;
    if (sw_reset_req) begin
      state_nxt = PLL_RESET;
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = QUALIFY;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt = PLL_RESET;
            retry_inc = 1'b1;
          end
        end
        QUALIFY: begin
          // Any drop restarts the wait; the timeout begins again from 0.
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt = PLL_RESET;
            retry_inc = 1'b1;
            lost_nxt  = 1'b1;
          end
        end
        default: state_nxt = PLL_RESET;
      endcase
    end
  end

  // State, shared counter and registered outputs. The level outputs are
  // decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PLL_RESET;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      lock_ok     <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      state <= state_nxt;

      // Held at 0 while a restart is requested and on every state change.
      // RUN has no terminal count, so the counter is simply parked there.
      if (sw_reset_req || (state_nxt != state)) begin
        cnt <= '0;
      end else if (state != RUN) begin
        cnt <= cnt + 1'b1;
      end

      pll_rst   <= (state_nxt == PLL_RESET);
      sys_rst_n <= (state_nxt == RUN);
      lock_ok   <= (state_nxt == RUN);
      lock_lost <= lost_nxt;

      if (retry_inc && (retry_count != 8'hFF)) begin
        retry_count <= retry_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Self-checking bench for pll_lock_supervisor with short timing parameters.
// A behavioural reference model tracks which phase the supervisor should be
// in and how many edges it has spent there. Each scenario task compares the
// DUT outputs against that model every cycle, and also checks the directed
// timing relations (pulse widths, release latency, reset values) with
// explicit arithmetic.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int P = 4;    // PLL reset width
  localparam int T = 20;   // lock timeout
  localparam int S = 8;    // qualification window

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_ok;
  logic       lock_lost;
  logic [7:0] retry_count;

  int errors = 0;
  int checks = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .CNT_W         (20)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .lock_ok     (lock_ok),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  always #10 refclk = ~refclk;

  // ---------------------------------------------------------------------------
  // Reference model: phase plus the edge number at which it was entered.
  // The lock input reaches the decision logic two edges after it is sampled.
  // ---------------------------------------------------------------------------
  localparam int M_RST  = 0;
  localparam int M_WAIT = 1;
  localparam int M_QUAL = 2;
  localparam int M_RUN  = 3;

  int   m_mode;
  int   m_n;       // edges since reset release
  int   m_e;       // edge at which the current phase was entered
  int   m_retry;
  bit   m_lost;
  bit   m_s1;
  bit   m_s2;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= M_RST;
      m_n     <= 0;
      m_e     <= 0;
      m_retry <= 0;
      m_lost  <= 1'b0;
      m_s1    <= 1'b0;
      m_s2    <= 1'b0;
    end else begin : model_step
      int n;
      int nm;
      int ne;
      int r;
      bit lost;
      n    = m_n + 1;
      nm   = m_mode;
      ne   = m_e;
      r    = m_retry;
      lost = 1'b0;
      if (sw_reset_req) begin
        nm = M_RST;
        ne = n;
      end else if (m_mode == M_RST) begin
        if (n - m_e == P) begin nm = M_WAIT; ne = n; end
      end else if (m_mode == M_WAIT) begin
        if (m_s2) begin
          nm = M_QUAL; ne = n;
        end else if (n - m_e == T) begin
          nm = M_RST; ne = n; r = (r < 255) ? r + 1 : 255;
        end
      end else if (m_mode == M_QUAL) begin
        if (!m_s2) begin
          nm = M_WAIT; ne = n;
        end else if (n - m_e == S) begin
          nm = M_RUN; ne = n;
        end
      end else begin
        if (!m_s2) begin
          nm = M_RST; ne = n; lost = 1'b1; r = (r < 255) ? r + 1 : 255;
        end
      end
      m_n     <= n;
      m_mode  <= nm;
      m_e     <= ne;
      m_retry <= r;
      m_lost  <= lost;
      m_s1    <= pll_locked;
      m_s2    <= m_s1;
    end
  end

  function automatic logic [11:0] dut_v();
    return {pll_rst, sys_rst_n, lock_ok, lock_lost, retry_count};
  endfunction

  function automatic logic [11:0] exp_v();
    return {(m_mode == M_RST), (m_mode == M_RUN), (m_mode == M_RUN), m_lost,
            8'(m_retry)};
  endfunction

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Restart the PLL and return right after the edge that enters WAIT_LOCK.
  task automatic goto_wait_lock();
    bit done;
    done = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    for (int i = 0; i < 3 * P && !done; i++) begin
      tick();
      if (!pll_rst) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_lock_entry: pll_rst=%b still high, expected low within %0d edges", pll_rst, 3 * P);
    end
  endtask

  // Bring the supervisor into RUN with a steady lock.
  task automatic goto_run();
    bit done;
    done = 1'b0;
    goto_wait_lock();
    pll_locked = 1'b1;
    for (int i = 0; i < S + 10 && !done; i++) begin
      tick();
      if (lock_ok) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL run_entry: lock_ok=%b, expected 1 within %0d edges", lock_ok, S + 10);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int first_low;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    #63;
    checks++;
    if (dut_v() !== 12'h800) begin
      errors++;
      $display("FAIL reset_values: got=%h expected=%h", dut_v(), 12'h800);
    end
    @(negedge refclk);
    rst_n = 1'b1;
    first_low = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL reset_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
      if (first_low == 0 && !pll_rst) first_low = i;
    end
    checks++;
    if (first_low != P) begin
      errors++;
      $display("FAIL reset_pll_rst_width: got=%0d expected=%0d", first_low, P);
    end
  endtask

  task automatic test_timeout();
    int  start_retry;
    int  rises;
    int  hi_run;
    int  lo_run;
    bit  prev;
    bit  seen_rise;
    bit  seen_fall;
    pll_locked  = 1'b0;
    start_retry = int'(retry_count);
    rises = 0; hi_run = 0; lo_run = 0;
    seen_rise = 1'b0; seen_fall = 1'b0;
    prev = pll_rst;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL timeout_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
      if (pll_rst && !prev) begin
        if (seen_fall) begin
          checks++;
          if (lo_run != T) begin
            errors++;
            $display("FAIL timeout_low_width: got=%0d expected=%0d", lo_run, T);
          end
        end
        seen_rise = 1'b1; rises++; hi_run = 0;
      end
      if (!pll_rst && prev) begin
        if (seen_rise) begin
          checks++;
          if (hi_run != P) begin
            errors++;
            $display("FAIL timeout_high_width: got=%0d expected=%0d", hi_run, P);
          end
        end
        seen_fall = 1'b1; lo_run = 0;
      end
      if (pll_rst) hi_run++; else lo_run++;
      prev = pll_rst;
    end
    checks++;
    if (int'(retry_count) != start_retry + rises) begin
      errors++;
      $display("FAIL timeout_retry_count: got=%0d expected=%0d", retry_count, start_retry + rises);
    end
  endtask

  task automatic test_lock_release();
    int  rel;
    int  r0;
    bit  any_lost;
    goto_wait_lock();
    r0 = int'(retry_count);
    pll_locked = 1'b1;          // first sampled at the next edge (k)
    rel = 0; any_lost = 1'b0;
    for (int i = 1; i <= S + 8; i++) begin
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL release_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
      if (rel == 0 && sys_rst_n) rel = i;
      if (lock_lost) any_lost = 1'b1;
    end
    checks++;
    if (rel != S + 3) begin     // k+2+S, with k one edge after the drive
      errors++;
      $display("FAIL release_latency: got=%0d expected=%0d", rel, S + 3);
    end
    checks++;
    if ({lock_ok, any_lost} !== 2'b10 || int'(retry_count) != r0) begin
      errors++;
      $display("FAIL release_flags: lock_ok=%b lost_seen=%b retry=%0d expected 1 0 %0d",
               lock_ok, any_lost, retry_count, r0);
    end
  endtask

  task automatic test_qualify_drop();
    int rel;
    bit early;
    goto_wait_lock();
    pll_locked = 1'b1;
    early = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 7) pll_locked = 1'b0;   // low for 3 sampled edges mid-QUALIFY
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL qual_drop_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
      if (sys_rst_n) early = 1'b1;
    end
    pll_locked = 1'b1;                 // new first high sample at the next edge
    rel = 0;
    for (int i = 1; i <= S + 8; i++) begin
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL qual_relock_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
      if (rel == 0 && sys_rst_n) rel = i;
      if (rel == 0 && i < S + 3 && sys_rst_n) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL qual_early_release: sys_rst_n went high during drop, expected 0");
    end
    checks++;
    if (rel != S + 3) begin
      errors++;
      $display("FAIL qual_relock_latency: got=%0d expected=%0d", rel, S + 3);
    end
  endtask

  task automatic test_run_loss();
    int r0;
    int hi;
    goto_run();
    r0 = int'(retry_count);
    pll_locked = 1'b0;          // first sampled low at edge k = i==1
    hi = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL loss_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
      if (i == 2) begin
        checks++;
        if ({sys_rst_n, lock_lost} !== 2'b10) begin
          errors++;
          $display("FAIL loss_before: sys_rst_n=%b lock_lost=%b expected 1 0", sys_rst_n, lock_lost);
        end
      end
      if (i == 3) begin
        checks++;
        if ({sys_rst_n, lock_ok, pll_rst, lock_lost} !== 4'b0011 ||
            int'(retry_count) != ((r0 < 255) ? r0 + 1 : 255)) begin
          errors++;
          $display("FAIL loss_edge: sys/ok/rst/lost=%b%b%b%b retry=%0d expected 0011 %0d",
                   sys_rst_n, lock_ok, pll_rst, lock_lost, retry_count,
                   (r0 < 255) ? r0 + 1 : 255);
        end
      end
      if (i == 4) begin
        checks++;
        if (lock_lost !== 1'b0) begin
          errors++;
          $display("FAIL loss_pulse_width: lock_lost=%b expected 0", lock_lost);
        end
      end
      if (i >= 3 && i <= 10 && pll_rst) hi++;
    end
    checks++;
    if (hi != P) begin
      errors++;
      $display("FAIL loss_pll_rst_width: got=%0d expected=%0d", hi, P);
    end
  endtask

  task automatic test_sw_reset();
    int r0;
    goto_run();
    r0 = int'(retry_count);
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    checks++;
    if ({pll_rst, sys_rst_n, lock_ok, lock_lost} !== 4'b1000 || int'(retry_count) != r0) begin
      errors++;
      $display("FAIL sw_reset_edge: rst/sys/ok/lost=%b%b%b%b retry=%0d expected 1000 %0d",
               pll_rst, sys_rst_n, lock_ok, lock_lost, retry_count, r0);
    end
    for (int i = 0; i < S + P + 6; i++) begin
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL sw_reset_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
    end
    checks++;
    if (int'(retry_count) != r0) begin
      errors++;
      $display("FAIL sw_reset_retry: got=%0d expected=%0d", retry_count, r0);
    end
  endtask

  task automatic test_async_reset();
    int rel;
    goto_wait_lock();
    pll_locked = 1'b1;
    repeat (5) tick();           // QUALIFY is under way
    #3;
    rst_n = 1'b0;                // between clock edges
    #1;
    checks++;
    if (dut_v() !== 12'h800) begin
      errors++;
      $display("FAIL async_reset_values: got=%h expected=%h", dut_v(), 12'h800);
    end
    @(negedge refclk);
    rst_n = 1'b1;
    rel = 0;
    for (int i = 1; i <= S + P + 6; i++) begin
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL async_restart_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
      if (rel == 0 && sys_rst_n) rel = i;
    end
    // P edges of PLL reset, one edge in WAIT_LOCK with lock already seen,
    // then S edges of qualification.
    checks++;
    if (rel != P + 1 + S) begin
      errors++;
      $display("FAIL async_restart_latency: got=%0d expected=%0d", rel, P + 1 + S);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
      sw_reset_req = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL random_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
    end
    sw_reset_req = 1'b0;
  endtask

  task automatic test_saturation();
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    for (int i = 0; i < 270 * (P + T); i++) begin
      tick();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL sat_model: t=%0t got=%h expected=%h", $time, dut_v(), exp_v());
      end
    end
    checks++;
    if (retry_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_reached: got=%0d expected=255", retry_count);
    end
    repeat (2 * (P + T)) tick();
    checks++;
    if (retry_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold: got=%0d expected=255", retry_count);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lock_release();
    test_qualify_drop();
    test_run_loss();
    test_sw_reset();
    test_async_reset();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the board PLL's reset and lock interface. Drives the PLL's active-high `rst`, samples its asynchronous `locked` output and retries the PLL when lock does not arrive within a timeout. Releases the design-wide active-low system reset only after lock has been continuously stable for a qualification window. Runs on the 50 MHz reference clock, because the PLL outputs are not trustworthy while unlocked.

## Interface
Parameters:
- `PLL_RST_CYCLES`, default 16: number of cycles `pll_rst` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, default 50000: cycles to wait for lock after `pll_rst` is released before retrying (≥1).
- `STABLE_CYCLES`, default 1024: cycles the synchronized lock must stay high before release (≥1).
- `CNT_W`, default 20: width of the shared cycle counter; must hold max(parameters)−1.

Ports (one clock; reset is asynchronous and active-low):
- `refclk`  in  1  reference clock, 50 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `pll_locked`  in  1  PLL `locked`, asynchronous to `refclk`.
- `sw_reset_req`  in  1  synchronous request to restart the PLL; level-sampled.
- `pll_rst`  out  1  to PLL `rst`, active-high.
- `sys_rst_n`  out  1  system reset to downstream logic, active-low.
- `lock_ok`  out  1  high while in RUN.
- `lock_lost`  out  1  one-cycle pulse on loss of lock from RUN.
- `retry_count`  out  8  saturating count of PLL re-reset attempts.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (both flops reset to 0) to give `locked_s`.
- State machine with four states: PLL_RESET, WAIT_LOCK, QUALIFY, RUN. One `CNT_W`-bit counter is cleared on every state change.
- **PLL_RESET:** `pll_rst`=1. When the counter reaches `PLL_RST_CYCLES`−1, go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0.
  - If `locked_s`=1, go to QUALIFY.
  - Otherwise, when the counter reaches `LOCK_TIMEOUT`−1, go to PLL_RESET and increment `retry_count`.
- **QUALIFY:**
  - If `locked_s`=0, go to WAIT_LOCK. The timeout restarts from 0.
  - When the counter reaches `STABLE_CYCLES`−1 with `locked_s`=1, go to RUN.
- **RUN:** `sys_rst_n`=1 and `lock_ok`=1. If `locked_s`=0, go to PLL_RESET, pulse `lock_lost` and increment `retry_count`.
- `sw_reset_req`=1 has highest priority in every state. It forces PLL_RESET at the next edge, does not increment `retry_count` and does not pulse `lock_lost`. While it is held high, the block stays in PLL_RESET with the counter at 0.
- `retry_count` saturates at 255 and is cleared only by `rst_n`.
- All outputs are registered. `pll_rst`, `sys_rst_n` and `lock_ok` are decoded from the next state, so they change on the same edge as the state.

## Timing
- Reset values while `rst_n`=0 (asynchronous): state PLL_RESET, counter 0, `pll_rst`=1, `sys_rst_n`=0, `lock_ok`=0, `lock_lost`=0, `retry_count`=0, synchronizer 0.
- After `rst_n` deassertion, `pll_rst` stays high for exactly `PLL_RST_CYCLES` edges.
- Lock to release: `pll_locked` is first sampled high at edge k.
  - `locked_s` is 1 after edge k+1.
  - QUALIFY is entered at edge k+2.
  - `sys_rst_n` and `lock_ok` rise at edge k+2+`STABLE_CYCLES`.
- A WAIT_LOCK with no lock lasts exactly `LOCK_TIMEOUT` cycles. `pll_rst` rises on the following edge.
- Loss of lock: `pll_locked` is first sampled low at edge k. At edge k+2:
  - `sys_rst_n`=0, `lock_ok`=0 and `pll_rst`=1.
  - `lock_lost`=1 for exactly that one cycle.
  - `retry_count` increments by 1.
- A low pulse on `pll_locked` of at most one cycle may be missed by the synchronizer; this is acceptable. Any drop seen in `locked_s` restarts qualification.
- `rst_n` asserted mid-operation forces all reset values immediately, without waiting for a clock edge.

## Test plan
Use `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8.
- `pll_locked`=0 throughout -> `pll_rst` repeats a pattern of 4 cycles high, 20 low. `retry_count` increments once per timeout; with the count forced to 255, it stays at 255.
- `pll_locked` rises and stays high in WAIT_LOCK, first sampled at edge k -> `sys_rst_n`=1 and `lock_ok`=1 at edge k+10. `lock_lost` stays 0 and `retry_count` is unchanged.
- `pll_locked` drops for 3 cycles midway through QUALIFY -> back to WAIT_LOCK and `sys_rst_n` stays 0. After lock returns, release occurs 10 edges after the new first high sample.
- `pll_locked` falls in RUN -> 2 edges later: `sys_rst_n`=0, one-cycle `lock_lost`, `pll_rst` high for 4 cycles, `retry_count`+1.
- `sw_reset_req` pulsed for 1 cycle in RUN -> at the next edge: PLL_RESET, `sys_rst_n`=0, `lock_lost`=0, `retry_count` unchanged.
- `rst_n` asserted mid-QUALIFY, between clock edges -> all outputs take reset values immediately, and the full sequence restarts after release.
